// File: rtl/adder_arbiter_4.sv
// adder_arbiter_4: round-robin arbiter sharing one 16-bit carry-select adder
// among up to four requesters, with lock (sticky priority) and carry chaining
// for multi-word additions.
module adder_arbiter_4 #(
   parameter int unsigned N_REQ = 4
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [N_REQ-1:0]    Req,
   input  logic [N_REQ*16-1:0] A,
   input  logic [N_REQ*16-1:0] B,
   input  logic [N_REQ-1:0]    Cin,
   input  logic [N_REQ-1:0]    Chain,
   input  logic [N_REQ-1:0]    Lock,
   input  logic [N_REQ-1:0]    Ack,
   output logic [N_REQ-1:0]    Gnt,
   output logic [N_REQ-1:0]    Valid,
   output logic [15:0]         Sum,
   output logic                Cout,
   output logic                Ovf
);

   localparam int unsigned IW = 2;
   localparam int unsigned DW = 16;
   localparam int unsigned NW = 4;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [IW-1:0]    last_owner_q, last_owner_d;
   logic             carry_q, carry_d;
   logic             chain_ok_q, chain_ok_d;
   logic [DW-1:0]    op_a_q, op_a_d;
   logic [DW-1:0]    op_b_q, op_b_d;
   logic             op_c_q, op_c_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [N_REQ-1:0] valid_q, valid_d;
   logic [DW-1:0]    sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [DW-1:0]    add_sum;
   logic             add_cout;
   logic             add_c;
   logic [NW:0]      blk0;
   logic [NW:0]      blk1;

   logic             req_found;
   logic [IW-1:0]    win;
   logic [IW:0]      cand;
   logic [IW-1:0]    next_owner;

   // Carry-select adder: each nibble precomputes both carry cases, the ripple only selects
   always_comb begin
      add_c   = op_c_q;
      add_sum = '0;
      blk0    = '0;
      blk1    = '0;
      for (int k = 0; k < DW / NW; k++) begin
         blk0 = (NW+1)'({1'b0, op_a_q[k*NW +: NW]}) + (NW+1)'({1'b0, op_b_q[k*NW +: NW]});
         blk1 = blk0 + (NW+1)'(1);
         {add_c, add_sum[k*NW +: NW]} = add_c ? blk1 : blk0;
      end
      add_cout = add_c;
   end

   // Round-robin search: first set Req at or above the pointer, wrapping around
   always_comb begin
      req_found = 1'b0;
      win       = '0;
      cand      = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(i);
         if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
         if (!req_found && Req[cand[IW-1:0]]) begin
            req_found = 1'b1;
            win       = cand[IW-1:0];
         end
      end
      next_owner = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
   end

   // Next-state and datapath register inputs
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      carry_d      = carry_q;
      chain_ok_d   = chain_ok_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      op_c_d       = op_c_q;
      gnt_d        = '0;
      valid_d      = valid_q;
      sum_d        = sum_q;
      cout_d       = cout_q;
      ovf_d        = ovf_q;
      case (state_q)
         IDLE: begin
            if (req_found) begin
               op_a_d  = A[{win, 4'b0000} +: DW];
               op_b_d  = B[{win, 4'b0000} +: DW];
               op_c_d  = (Chain[win] && chain_ok_q && (last_owner_q == win)) ? carry_q : Cin[win];
               owner_d = win;
               gnt_d   = N_REQ'(1) << win;
               state_d = EXEC;
            end
         end
         EXEC: begin
            sum_d        = add_sum;
            cout_d       = add_cout;
            ovf_d        = (op_a_q[DW-1] == op_b_q[DW-1]) && (add_sum[DW-1] != op_a_q[DW-1]);
            carry_d      = add_cout;
            last_owner_d = owner_q;
            chain_ok_d   = 1'b1;
            valid_d      = N_REQ'(1) << owner_q;
            state_d      = DONE;
         end
         DONE: begin
            if (Ack[owner_q]) begin
               valid_d = '0;
               ptr_d   = Lock[owner_q] ? owner_q : next_owner;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         owner_q      <= '0;
         last_owner_q <= '0;
         carry_q      <= 1'b0;
         chain_ok_q   <= 1'b0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_c_q       <= 1'b0;
         gnt_q        <= '0;
         valid_q      <= '0;
         sum_q        <= '0;
         cout_q       <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         carry_q      <= carry_d;
         chain_ok_q   <= chain_ok_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         op_c_q       <= op_c_d;
         gnt_q        <= gnt_d;
         valid_q      <= valid_d;
         sum_q        <= sum_d;
         cout_q       <= cout_d;
         ovf_q        <= ovf_d;
      end
   end

   assign Gnt   = gnt_q;
   assign Valid = valid_q;
   assign Sum   = sum_q;
   assign Cout  = cout_q;
   assign Ovf   = ovf_q;

endmodule

// File: doc/adder_arbiter_4.md
# adder_arbiter_4

Round-robin arbiter and sequencer that shares one 16-bit carry-select adder among up to four requesters. Each transaction captures one requester's operands, performs one 16-bit add through the shared adder, and returns a registered sum with a valid/ack handshake. A lock/chain mechanism lets one requester keep the adder across consecutive words and feed the previous carry-out forward. This supports 32-bit and wider multi-word additions without a wider adder.

## Interface
- N_REQ, 4, number of requesters (2..4); requester index 0 is lowest.
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high reset
- Req  in  N_REQ  per-requester request; held high until the matching Gnt bit is seen
- A  in  N_REQ x 16  per-requester operand A
- B  in  N_REQ x 16  per-requester operand B
- Cin  in  N_REQ  per-requester carry-in for a non-chained add
- Chain  in  N_REQ  per-requester flag: use stored carry instead of Cin
- Lock  in  N_REQ  per-requester flag, sampled with Ack: keep priority for the next transaction
- Ack  in  N_REQ  per-requester result acknowledge
- Gnt  out  N_REQ  one-hot, one-cycle pulse: operands of that requester were captured
- Valid  out  N_REQ  one-hot: result for that requester is on Sum/Cout/Ovf
- Sum  out  16  registered sum
- Cout  out  1  registered carry-out
- Ovf  out  1  registered signed overflow

## Operation
- Datapath: one instance of the team's 16-bit carry-select adder, driven only from internal operand registers (opA, opB, opC).
- FSM states:
  - IDLE: if no Req bit is set, stay in IDLE. Otherwise, pick the first set Req bit searching upward from the priority pointer, with wrap-around. Then latch opA=A[w], opB=B[w], owner=w, and the carry opC. Go to EXEC.
  - Carry selection: opC = carry_reg if Chain[w]=1 && chain_ok && last_owner==w; otherwise opC = Cin[w].
  - EXEC: Gnt[owner]=1 for this cycle only. Register Sum, Cout, and Ovf = (opA[15]==opB[15]) && (sum[15]!=opA[15]). Also set carry_reg=Cout, last_owner=owner, chain_ok=1. Go to DONE.
  - DONE: Valid[owner]=1, result held stable. Stay until Ack[owner]=1. On that Ack, go to IDLE and update the pointer: pointer=owner if Lock[owner]=1, else pointer=(owner+1) mod N_REQ.
- Ack bits of non-owners and Ack in IDLE or EXEC are ignored.
- Req bits arriving in EXEC or DONE are not captured until the next IDLE.
- Chain requested by a requester other than last_owner, or with chain_ok=0: Cin is used, and no error is flagged.
- Lock affects only arbitration priority. If the locked owner drops Req, the next set Req bit upward from the pointer wins.
- Simultaneous Req in IDLE: exactly one grant, decided by the pointer.
- Reset, including mid-transaction:
  - State goes to IDLE; pointer=0, owner=0, last_owner=0.
  - carry_reg=0, chain_ok=0.
  - Gnt=0, Valid=0, Sum=0, Cout=0, Ovf=0.
  - Any in-flight result is discarded; the requester must re-request.

## Timing
- Req seen in IDLE at cycle T: Gnt pulse at T+1 (EXEC), Valid and result from T+2 (DONE).
- Ack at cycle D (in DONE): Valid low at D+1 (IDLE). New capture possible at D+1, Gnt at D+2.
- Best-case throughput: one add per 3 cycles, with Ack in the first DONE cycle.
- Sum, Cout, and Ovf change only on the EXEC→DONE edge and on Reset. They hold their last values in IDLE.
- Gnt and Valid are registered outputs, never both high, and at most one bit of each is set.
- Requester's obligation: hold A/B/Cin/Chain valid from Req rise until Gnt is seen.

## Test plan
- After reset, Req=0100, A[2]=0x1234, B[2]=0x0FFF, Cin[2]=0 -> Gnt=0100 at T+1; Valid=0100, Sum=0x2233, Cout=0, Ovf=0 at T+2; Ack[2] drops Valid next cycle.
- Req=1111 held continuously, Ack returned immediately, Lock=0 -> Gnt order 0,1,2,3,0, one grant every 3 cycles.
- 32-bit add 0x0000FFFF+0x00000001 by requester 1 with Req[0] also high:
  - Low word 0xFFFF+0x0001 with Lock=1 on Ack -> Sum=0x0000, Cout=1.
  - High word 0x0000+0x0000 with Chain=1 -> grant goes to 1 again, Sum=0x0001, Cout=0.
- Requester 3 with Chain=1, Cin=0 immediately after requester 1's carry-out=1 -> stored carry not used; 0x0001+0x0001 gives Sum=0x0002.
- Requester 0, 0x7FFF+0x0001, Cin=0 -> Sum=0x8000, Ovf=1, Cout=0. Then 0xFFFF+0xFFFF -> Sum=0xFFFE, Cout=1, Ovf=0.
- Reset asserted for one cycle in DONE (Valid=0010) -> next cycle Valid=0, Sum=0, pointer=0. With Req=1010 pending, the next grant goes to requester 1.
